// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } lsu_op_t;

    localparam logic [15:0] DMEM_BASE = 16'h2000;
    localparam logic [15:0] DMEM_LAST = 16'h3FFF;

    // Store byte-lane mask; only B/H/W are legal store widths.
    function automatic logic [3:0] lane_mask(input logic [2:0] op, input logic [1:0] a);
        case (op)
            OP_B:    lane_mask = 4'b0001 << a;
            OP_H:    lane_mask = a[1] ? 4'b1100 : 4'b0011;
            OP_W:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - four byte-lane data RAM, synchronous write, combinational read
module dmem_sram #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int WORDS = 1 << AW;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [WORDS];

        always_ff @(posedge clk) begin
            if (we[g]) begin
                mem[addr] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - LSU data-memory responder with fixed response latency
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY   = 2,
    parameter int MEM_BYTES = 8192
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        i_wren,
    input  logic [2:0]  i_lsu_op,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_busy
);

    localparam int BAW = $clog2(MEM_BYTES);
    localparam int WAW = BAW - 2;

    state_t         state;
    state_t         state_nx;
    logic [3:0]     cnt;
    logic [15:0]    addr_q;
    logic           wren_q;
    logic [2:0]     op_q;
    logic [31:0]    wdata_q;
    logic [WAW-1:0] word_addr;
    logic           err;
    logic [3:0]     we;
    logic [31:0]    wr_word;
    logic [31:0]    rd_word;
    logic [31:0]    load_val;
    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (i_req) state_nx = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt <= 4'd1) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_ack   = 1'b0;
        o_err   = 1'b0;
        o_rdata = 32'h0;
        o_busy  = (state != IDLE);
        if (state == RESP) begin
            o_ack = 1'b1;
            o_err = err;
            if (!wren_q && !err) begin
                o_rdata = load_val;
            end
        end
    end

    // Request fields are captured once at acceptance and held until the next one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= 4'd0;
            addr_q  <= 16'h0;
            wren_q  <= 1'b0;
            op_q    <= 3'b0;
            wdata_q <= 32'h0;
        end else if (state == IDLE && i_req) begin
            cnt     <= 4'(LATENCY);
            addr_q  <= i_addr;
            wren_q  <= i_wren;
            op_q    <= i_lsu_op;
            wdata_q <= i_wdata;
        end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        err = (addr_q < DMEM_BASE) || (addr_q > DMEM_LAST);
        case (op_q)
            OP_B:    ;
            OP_H:    if (addr_q[0]) err = 1'b1;
            OP_W:    if (addr_q[1:0] != 2'b00) err = 1'b1;
            OP_BU:   if (wren_q) err = 1'b1;
            OP_HU:   if (wren_q || addr_q[0]) err = 1'b1;
            default: err = 1'b1;
        endcase
    end

    // Base is word aligned, so subtracting on the word-index bits alone is exact.
    assign word_addr = addr_q[BAW-1:2] - DMEM_BASE[BAW-1:2];

    assign we = (state == RESP && wren_q && !err) ? lane_mask(op_q, addr_q[1:0]) : 4'b0000;

    always_comb begin
        case (op_q)
            OP_B:    wr_word = {4{wdata_q[7:0]}};
            OP_H:    wr_word = {2{wdata_q[15:0]}};
            default: wr_word = wdata_q;
        endcase
    end

    assign ld_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (op_q)
            OP_B:    load_val = {{24{ld_byte[7]}}, ld_byte};
            OP_BU:   load_val = {24'h0, ld_byte};
            OP_H:    load_val = {{16{ld_half[15]}}, ld_half};
            OP_HU:   load_val = {16'h0, ld_half};
            OP_W:    load_val = rd_word;
            default: load_val = 32'h0;
        endcase
    end

    dmem_sram #(
        .AW(WAW)
    ) u_sram (
        .clk   (i_clk),
        .we    (we),
        .addr  (word_addr),
        .wdata (wr_word),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 2;
    localparam int NV  = 30;

    typedef struct {
        logic        wren;
        logic [2:0]  op;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        z_req;
    logic [15:0] addr;
    logic        wren;
    logic [2:0]  op;
    logic [31:0] wdata;
    logic        ack, err, busy;
    logic [31:0] rdata;
    logic        z_ack, z_err, z_busy;
    logic [31:0] z_rdata;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [32:0] exp_q [$];
    logic [32:0] mon_e;
    vec_t        vecs [NV];

    dmem_responder #(.LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_addr(addr), .i_wren(wren),
        .i_lsu_op(op), .i_wdata(wdata), .o_ack(ack), .o_rdata(rdata), .o_err(err), .o_busy(busy)
    );

    dmem_responder #(.LATENCY(0)) dut_l0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(z_req), .i_addr(addr), .i_wren(wren),
        .i_lsu_op(op), .i_wdata(wdata), .o_ack(z_ack), .o_rdata(z_rdata), .o_err(z_err), .o_busy(z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack) begin
                check("ack_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("rdata", rdata, mon_e[32:1]);
                    check("err", 32'(err), 32'(mon_e[0]));
                end
            end else begin
                check("idle_rdata", rdata, 32'h0);
                check("idle_err", 32'(err), 32'h0);
            end
        end
    end

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 20);
        check(name, 32'(n), 32'(LAT + 1));
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int  n;
        bit  got;
        @(negedge clk);
        req = 1'b1; wren = v.wren; op = v.op; addr = v.addr; wdata = v.wdata;
        @(posedge clk);
        #1;
        req = 1'b0;
        exp_q.push_back({v.exp_rdata, v.exp_err});
        wren = 1'($urandom); op = 3'($urandom); addr = 16'($urandom); wdata = $urandom;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            got = ack;
            if (!got) check($sformatf("busy_wait[%0d]", idx), 32'(busy), 32'd1);
        end
        check($sformatf("latency[%0d]", idx), 32'(n), 32'(LAT + 1));
    endtask

    initial begin
        vecs[0]  = '{1'b1, OP_W,   16'h2004, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, OP_W,   16'h2004, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, OP_B,   16'h2005, 32'h00000080, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, OP_B,   16'h2005, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, OP_BU,  16'h2005, 32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, OP_W,   16'h2004, 32'h0,        32'hDEAD80EF, 1'b0};
        vecs[6]  = '{1'b0, OP_H,   16'h2003, 32'h0,        32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, OP_W,   16'h2000, 32'hCAFEF00D, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, OP_W,   16'h4000, 32'h12345678, 32'h00000000, 1'b1};
        vecs[9]  = '{1'b0, OP_W,   16'h2000, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[10] = '{1'b1, OP_H,   16'h2006, 32'hABCD8001, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, OP_H,   16'h2006, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[12] = '{1'b0, OP_HU,  16'h2006, 32'h0,        32'h00008001, 1'b0};
        vecs[13] = '{1'b0, OP_W,   16'h2004, 32'h0,        32'h800180EF, 1'b0};
        vecs[14] = '{1'b1, OP_B,   16'h3FFF, 32'h0000007F, 32'h00000000, 1'b0};
        vecs[15] = '{1'b0, OP_B,   16'h3FFF, 32'h0,        32'h0000007F, 1'b0};
        vecs[16] = '{1'b0, OP_W,   16'h2002, 32'h0,        32'h00000000, 1'b1};
        vecs[17] = '{1'b0, 3'b011, 16'h2000, 32'h0,        32'h00000000, 1'b1};
        vecs[18] = '{1'b1, OP_BU,  16'h2000, 32'h11111111, 32'h00000000, 1'b1};
        vecs[19] = '{1'b0, OP_W,   16'h2000, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[20] = '{1'b0, OP_B,   16'h1FFF, 32'h0,        32'h00000000, 1'b1};
        vecs[21] = '{1'b0, OP_H,   16'h2001, 32'h0,        32'h00000000, 1'b1};
        vecs[22] = '{1'b1, OP_W,   16'h2008, 32'h55AA55AA, 32'h00000000, 1'b0};
        vecs[23] = '{1'b1, OP_H,   16'h2001, 32'h99999999, 32'h00000000, 1'b1};
        vecs[24] = '{1'b0, OP_W,   16'h2000, 32'h0,        32'hCAFEF00D, 1'b0};
        vecs[25] = '{1'b0, OP_HU,  16'h2002, 32'h0,        32'h0000CAFE, 1'b0};
        vecs[26] = '{1'b0, OP_B,   16'h2003, 32'h0,        32'hFFFFFFCA, 1'b0};
        vecs[27] = '{1'b1, 3'b111, 16'h2000, 32'h77777777, 32'h00000000, 1'b1};
        vecs[28] = '{1'b0, OP_H,   16'h2000, 32'h0,        32'hFFFFF00D, 1'b0};
        vecs[29] = '{1'b0, OP_W,   16'h4000, 32'h0,        32'h00000000, 1'b1};

        rst_n = 1'b0; req = 1'b0; z_req = 1'b0;
        addr = 16'h0; wren = 1'b0; op = 3'b0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ack",    32'(ack),  32'd0);
        check("rst_err",    32'(err),  32'd0);
        check("rst_rdata",  rdata,     32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_busy_l0", 32'(z_busy), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_txn(vecs[i], i);
        end

        // A request pulse during WAIT (a store to 0x2000) must be ignored.
        @(negedge clk);
        req = 1'b1; wren = 1'b0; op = OP_W; addr = 16'h2004;
        @(posedge clk);
        #1;
        req = 1'b0;
        exp_q.push_back({32'h800180EF, 1'b0});
        @(negedge clk);
        check("pulse_busy", 32'(busy), 32'd1);
        req = 1'b1; wren = 1'b1; op = OP_W; addr = 16'h2000; wdata = 32'h0;
        @(negedge clk);
        req = 1'b0;
        repeat (6) @(negedge clk);
        check("pulse_one_ack", 32'(exp_q.size()), 32'd0);
        run_txn('{1'b0, OP_W, 16'h2000, 32'h0, 32'hCAFEF00D, 1'b0}, 100);

        // i_req held through the ack is taken as a new request in the next IDLE cycle.
        @(negedge clk);
        req = 1'b1; wren = 1'b0; op = OP_W; addr = 16'h2004;
        exp_q.push_back({32'h800180EF, 1'b0});
        @(posedge clk);
        wait_ack("hold_first_latency");
        addr = 16'h2000;
        exp_q.push_back({32'hCAFEF00D, 1'b0});
        @(negedge clk);
        check("hold_idle_gap", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        req = 1'b0;
        wait_ack("hold_second_latency");
        repeat (2) @(negedge clk);
        check("hold_drained", 32'(exp_q.size()), 32'd0);

        // Reset during WAIT aborts the store with no ack.
        @(negedge clk);
        req = 1'b1; wren = 1'b1; op = OP_W; addr = 16'h2008; wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",  32'(busy), 32'd0);
        check("abort_ack",   32'(ack),  32'd0);
        check("abort_rdata", rdata,     32'd0);
        check("abort_err",   32'(err),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        run_txn('{1'b0, OP_W, 16'h2008, 32'h0, 32'h55AA55AA, 1'b0}, 101);

        // Zero-latency build: ack in the cycle right after acceptance.
        @(negedge clk);
        z_req = 1'b1; wren = 1'b1; op = OP_W; addr = 16'h2010; wdata = 32'h0BADCAFE;
        @(posedge clk);
        #1;
        z_req = 1'b0;
        @(negedge clk);
        check("l0_st_ack",  32'(z_ack),  32'd1);
        check("l0_st_busy", 32'(z_busy), 32'd1);
        check("l0_st_err",  32'(z_err),  32'd0);
        @(negedge clk);
        check("l0_st_ack_off",  32'(z_ack),  32'd0);
        check("l0_st_busy_off", 32'(z_busy), 32'd0);
        z_req = 1'b1; wren = 1'b0; op = OP_W; addr = 16'h2010;
        @(posedge clk);
        #1;
        z_req = 1'b0;
        @(negedge clk);
        check("l0_ld_ack",   32'(z_ack), 32'd1);
        check("l0_ld_rdata", z_rdata,    32'h0BADCAFE);
        @(negedge clk);
        check("l0_ld_ack_off", 32'(z_ack), 32'd0);
        check("l0_ld_rdata_off", z_rdata,  32'd0);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
